// File: rtl/fp_decode.sv
// Iterative 8-bit float {S,E,F} to two's-complement linear decoder.
// Shifts the significand left one place per cycle, then applies the sign.
module fp_decode #(
  parameter int unsigned W_E = 3,
  parameter int unsigned W_F = 4,
  parameter int unsigned W_D = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_s,
  input  logic [W_E-1:0] in_e,
  input  logic [W_F-1:0] in_f,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_D-1:0] out_d
);

  // Magnitude is one bit narrower than the output; the top bit is reserved for the sign.
  localparam int unsigned W_M = W_D - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, HOLD} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W_M-1:0] mag;
  logic [W_E-1:0] cnt;
  logic           sgn;
  logic [W_D-1:0] mag_ext;
  logic           load_c;
  logic           shift_c;
  logic           emit_c;
  logic           retire_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)       state_nxt = SIGN;
      SIGN:                         state_nxt = HOLD;
      HOLD:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Control strobes and ready decode
  always_comb begin
    in_ready = 1'b0;
    load_c   = 1'b0;
    shift_c  = 1'b0;
    emit_c   = 1'b0;
    retire_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load_c   = in_valid;
      end
      SHIFT:   shift_c  = (cnt != '0);
      SIGN:    emit_c   = 1'b1;
      HOLD:    retire_c = out_ready;
      default: ;
    endcase
  end

  assign mag_ext = {1'b0, mag};

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      out_valid <= 1'b0;
      out_d     <= '0;
    end else begin
      if (load_c) begin
        mag <= W_M'(in_f);
        cnt <= in_e;
        sgn <= in_s;
      end else if (shift_c) begin
        mag <= mag << 1;
        cnt <= cnt - W_E'(1);
      end
      // Negating a zero magnitude yields zero, so -0 decodes to 0 naturally.
      if (emit_c) begin
        out_d     <= sgn ? (~mag_ext + W_D'(1)) : mag_ext;
        out_valid <= 1'b1;
      end else if (retire_c) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_decode.sv
// Randomized scoreboard bench for fp_decode: directed corners, random floats,
// and a full round trip of every 12-bit linear value through a reference encoder.
module tb_fp_decode;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [2:0]  in_e;
  logic [3:0]  in_f;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_d;

  fp_decode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_f      (in_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d)
  );

  typedef struct {
    logic [11:0] exp_d;
    int          d;
    int          e;
    bit          rt;
    int          acc;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    rdy_mode;  // 0 random, 1 hold low, 2 hold high

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference value: (-1)^S * F * 2^E, as a 12-bit two's-complement word
  function automatic logic [11:0] model(input bit s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s) v = -v;
    return 12'(v);
  endfunction

  // Reference encoder: clamp to 1920, smallest exponent whose rounded significand fits 4 bits
  task automatic encode(input int d, output bit s, output int e, output int f);
    int m;
    s = (d < 0);
    m = s ? -d : d;
    if (m > 1920) m = 1920;
    e = 0;
    f = m;
    for (int k = 0; k < 8; k++) begin
      int r;
      r = (k == 0) ? m : ((m + (1 << (k - 1))) >> k);
      if (r <= 15) begin
        e = k;
        f = r;
        break;
      end
    end
  endtask

  // Out_ready driver, changed well after the edge so it is stable at sampling
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input bit s, input int e, input int f, input bit rt, input int d,
                      input bit track);
    int    guard;
    item_t it;
    guard    = 0;
    in_s     = s;
    in_e     = 3'(e);
    in_f     = 4'(f);
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      it.exp_d = model(s, e, f);
      it.d     = d;
      it.e     = e;
      it.rt    = rt;
      it.acc   = cyc + 1;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_s     = 1'($urandom);
    in_e     = 3'($urandom);
    in_f     = 4'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  // Monitor: latency, hold stability, retirement, and scoreboard comparison
  initial begin
    bit          pv;
    bit          pf;
    logic [11:0] pd;
    item_t       it;
    int          dec;
    int          diff;
    pv = 1'b0;
    pf = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pf = 1'b0;
        continue;
      end
      if (pf) begin
        chk("retire_valid", int'(out_valid), 0);
        chk("retire_in_ready", int'(in_ready), 1);
      end
      if (out_valid && !pv) begin
        if (q.size() == 0) chk("unexpected_out", int'(out_valid), 0);
        else               chk("latency", cyc - q[0].acc, q[0].e + 2);
      end
      if (out_valid && pv) begin
        chk("hold_stable", int'(out_d), int'(pd));
        chk("hold_in_ready", int'(in_ready), 0);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        it = q.pop_front();
        chk("out_d", int'(out_d), int'(it.exp_d));
        if (it.rt) begin
          dec  = int'($signed(out_d));
          diff = (dec > it.d) ? dec - it.d : it.d - dec;
          if (it.d > 1920 || it.d < -1920)
            chk("rt_saturate", dec, (it.d > 0) ? 1920 : -1920);
          else
            chk("rt_error_bound", int'(2 * diff <= (1 << it.e)), 1);
        end
      end
      pv = out_valid;
      pd = out_d;
      pf = out_valid && out_ready;
    end
  end

  initial begin
    #950000;
    errors++;
    $display("FAIL watchdog actual=%0d cycles required=completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit s;
    int e;
    int f;
    int guard;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_s     = 1'b0;
    in_e     = '0;
    in_f     = '0;
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_d", int'(out_d), 0);
    chk("reset_in_ready", int'(in_ready), 1);

    // Corner values: zero, full scale, negative, negative zero
    send(1'b0, 0, 0, 1'b0, 0, 1'b1);
    drain();
    send(1'b0, 7, 15, 1'b0, 0, 1'b1);
    drain();
    send(1'b1, 3, 11, 1'b0, 0, 1'b1);
    send(1'b1, 0, 0, 1'b0, 0, 1'b1);
    send(1'b1, 7, 15, 1'b0, 0, 1'b1);
    drain();

    // Backpressure: result held in HOLD with out_ready low
    rdy_mode = 1;
    send(1'b1, 5, 13, 1'b0, 0, 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("hold_reached", int'(out_valid), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_valid_after_5", int'(out_valid), 1);
    chk("hold_d_after_5", int'(out_d), int'(model(1'b1, 5, 13)));
    rdy_mode = 2;
    drain();

    // Reset in the middle of a shift sequence
    send(1'b0, 6, 9, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_out_d", int'(out_d), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    repeat (15) @(posedge clk);
    #1;
    chk("no_stale_result", int'(out_valid), 0);

    // Random floats with random backpressure and idle gaps
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
           1'b0, 0, 1'b1);
    end
    drain();

    // Round trip of every linear value through the reference encoder
    rdy_mode = 2;
    for (int d = -2048; d < 2048; d++) begin
      encode(d, s, e, f);
      send(s, e, f, 1'b1, d, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
